rc_byte_packer: RTL and testbench
=================================

# rc_byte_packer

Downstream stage of the range-coder encoder. Takes the encoder's byte strobe (one compressed byte per `i_we` cycle plus a finish level) and packs bytes little-endian into 32-bit words. Words are buffered in a small FIFO and presented on a valid/ready stream with byte-keep and last markers. Feeds the DMA/BRAM writer, replacing direct byte-wide BRAM writes.

## Interface
- `FIFO_DEPTH`, 8: word FIFO depth; power of two, ≥2.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_we`  in  1  byte strobe; each high cycle is exactly one byte.
- `i_byte`  in  8  byte, valid when `i_we`=1.
- `i_finish`  in  1  encoder-finished level; its rising edge starts the flush.
- `o_tdata`  out  32  packed word; byte k in bits [8k+7:8k], k=0 first received.
- `o_tkeep`  out  4  valid byte lanes, contiguous from lane 0.
- `o_tlast`  out  1  final word of the stream.
- `o_tvalid`  out  1  FIFO non-empty.
- `i_tready`  in  1  consumer accepts; transfer = `o_tvalid` & `i_tready`.
- `o_byte_count`  out  32  bytes accepted, excluding dropped bytes.
- `o_overflow`  out  1  sticky; set when a push finds the FIFO full.
- `o_done`  out  1  high once the last word has been transferred, or at flush with zero bytes.

## Operation
- Pack register `pack[31:0]` and lane counter `lane[1:0]`. Accepted byte goes to lane `lane`, and `lane` increments modulo 4.
- A fourth byte completes a word. The completed word moves into hold register `hold` (`hold_v`=1) and is not pushed yet, so that tlast can mark it later.
- When `hold_v`=1 and a new byte is accepted, `hold` is pushed (keep 1111, last 0) on the same edge.
- Finish edge: `fin_d` registers `i_finish`. Edge = `i_finish & ~fin_d`, honoured only in ACCUM.
- States:
  - **ACCUM**: normal packing. On the finish edge go to FLUSH_HOLD.
  - **FLUSH_HOLD**:
    - If `hold_v`=1, push `hold` with last = (`lane`==0), then clear `hold_v`.
    - Then go to FLUSH_PART if `lane`≠0, else go to DRAIN.
  - **FLUSH_PART**: push `pack` with keep = (1<<`lane`)-1, last=1, unused lanes 0; go to DRAIN.
  - **DRAIN**: wait until the FIFO is empty after a transfer with last=1; go to DONE. If zero bytes were accepted in total, FLUSH_HOLD goes straight to DONE.
  - **DONE**: `o_done`=1. Stays here until reset. All `i_we` is ignored.
- The byte and the finish edge may arrive in the same cycle. The byte is accepted first and counted; the flush uses the updated `lane`/`hold`.
- `i_we` in FLUSH_*/DRAIN/DONE is ignored, not counted, and does not set overflow.
- A push into a full FIFO drops the word and sets `o_overflow`. `o_byte_count` still counts bytes that were accepted into `pack`. A push and a pop in the same cycle on a full FIFO succeed.
- `o_byte_count` is 32-bit and wraps modulo 2^32.

## Timing
- Reset values (all registers): `o_tvalid`=0, `o_tdata`=0, `o_tkeep`=0, `o_tlast`=0, `o_byte_count`=0, `o_overflow`=0, `o_done`=0, state ACCUM, `lane`=0, `hold_v`=0, `fin_d`=0, FIFO empty. Reset mid-stream discards everything.
- Push latency:
  - A full word is pushed on the edge of the 5th byte, or in the FLUSH_HOLD cycle.
  - `o_tvalid` is combinational from the FIFO count, high in the cycle after the push edge.
- Flush: finish edge seen at edge t. FLUSH_HOLD occupies the cycle after t, and FLUSH_PART the one after that.
- Stream rules: `o_tdata/o_tkeep/o_tlast` are stable while `o_tvalid` & ~`i_tready`. `o_tvalid` never drops without a transfer.
- Throughput: one byte per cycle in, one word per cycle out.
- `o_done` rises on the edge after the last transfer and holds.

## Structure
- Shared package `rc_pkg`: state encoding (ACCUM, FLUSH_HOLD, FLUSH_PART, DRAIN, DONE), `WORD_W`=32, `BYTE_W`=8, keep-mask function.
- Sub-module `rc_word_fifo`: synchronous, FIFO_DEPTH × (32+4+1) bits, first-word fall-through, full/empty from an extra pointer bit.
- Top level holds the packer, the FSM and the counters.

## Test plan
- Bytes 01..08, `i_tready`=1, then finish → two words: 0x04030201 keep F last 0, then 0x08070605 keep F last 1. `o_byte_count`=8, `o_done`=1.
- Bytes AA,BB,CC,DD,EE then finish → 0xDDCCBBAA keep F last 0, then 0x000000EE keep 1 last 1.
- Finish with zero bytes → no transfer, `o_done`=1 two cycles after the edge, count 0.
- `i_tready`=0, 40 bytes (10 words), FIFO_DEPTH 8 → FIFO fills, `o_overflow`=1. Output is exactly 8 words 0x03020100.. in order, data stable while stalled.
- Last byte and finish rise in the same cycle after 6 bytes → byte counted, final word keep 3 last 1. A byte after finish is ignored, count stays 6.
- Reset asserted mid-stream after 3 bytes, then 4 new bytes → only the new word appears, `o_byte_count`=4.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared types and helpers for the range-coder byte packer.
// Holds the flush FSM encoding, the FIFO word layout and lane-mask helpers.
package rc_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEEP_W = WORD_W / BYTE_W;

    typedef enum logic [2:0] {
        StAccum,
        StFlushHold,
        StFlushPart,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } word_t;

    // Lane count 0 means a complete word.
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [1:0] lane);
        logic [KEEP_W-1:0] m;
        case (lane)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [WORD_W-1:0] byte_mask(input logic [KEEP_W-1:0] keep);
        logic [WORD_W-1:0] m;
        for (int k = 0; k < KEEP_W; k++) begin
            m[k*BYTE_W +: BYTE_W] = {BYTE_W{keep[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/rc_word_fifo.sv
// First-word fall-through word FIFO; full/empty come from an extra pointer bit.
// A push into a full FIFO is dropped unless a pop happens on the same edge.
module rc_word_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 37
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic [Width-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_drop  = i_push && !do_push;

    // Empty output reads as zero so the stream is clean out of reset.
    assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/rc_byte_packer.sv
// Packs encoder bytes little-endian into 32-bit words on a valid/ready stream.
// The newest complete word is held back so the flush can tag it as last.
module rc_byte_packer
    import rc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_finish,
    output logic [WORD_W-1:0] o_tdata,
    output logic [KEEP_W-1:0] o_tkeep,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              i_tready,
    output logic [31:0]       o_byte_count,
    output logic              o_overflow,
    output logic              o_done
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_v_q, hold_v_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       count_q, count_d;
    logic              fin_q;
    logic              overflow_q;

    logic  fin_edge, accept, push, pop;
    word_t push_word, fifo_rdata;
    logic  fifo_empty, fifo_full, fifo_drop;

    assign fin_edge = i_finish & ~fin_q;
    assign accept   = i_we && (state_q == StAccum);
    assign pop      = o_tvalid && i_tready;

    always_comb begin
        state_d   = state_q;
        pack_d    = pack_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        lane_d    = lane_q;
        count_d   = count_q;
        push      = 1'b0;
        push_word = '0;
        case (state_q)
            StAccum: begin
                if (accept) begin
                    pack_d[{lane_q, 3'b000} +: BYTE_W] = i_byte;
                    lane_d  = lane_q + 2'd1;
                    count_d = count_q + 32'd1;
                    if (hold_v_q) begin
                        push      = 1'b1;
                        push_word = '{data: hold_q, keep: 4'b1111, last: 1'b0};
                        hold_v_d  = 1'b0;
                    end
                    if (lane_q == 2'd3) begin
                        hold_d   = {i_byte, pack_q[23:0]};
                        hold_v_d = 1'b1;
                    end
                end
                if (fin_edge) state_d = StFlushHold;
            end
            StFlushHold: begin
                if (hold_v_q) begin
                    push      = 1'b1;
                    push_word = '{data: hold_q, keep: 4'b1111, last: (lane_q == 2'd0)};
                    hold_v_d  = 1'b0;
                end
                // lane 0 with nothing held means no byte was ever accepted.
                if (lane_q != 2'd0)  state_d = StFlushPart;
                else if (hold_v_q)   state_d = StDrain;
                else                 state_d = StDone;
            end
            StFlushPart: begin
                push      = 1'b1;
                push_word = '{data: pack_q & byte_mask(keep_mask(lane_q)),
                              keep: keep_mask(lane_q), last: 1'b1};
                state_d   = StDrain;
            end
            StDrain: begin
                // Empty without a last transfer means the last word was dropped.
                if ((pop && fifo_rdata.last) || fifo_empty) state_d = StDone;
            end
            StDone: ;
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StAccum;
            pack_q     <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            lane_q     <= 2'd0;
            count_q    <= '0;
            fin_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pack_q     <= pack_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            lane_q     <= lane_d;
            count_q    <= count_d;
            fin_q      <= i_finish;
            overflow_q <= overflow_q | fifo_drop;
        end
    end

    rc_word_fifo #(
        .Depth (FIFO_DEPTH),
        .Width ($bits(word_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_wdata (push_word),
        .i_pop   (pop),
        .o_rdata (fifo_rdata),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_drop  (fifo_drop)
    );

    assign o_tvalid     = ~fifo_empty;
    assign o_tdata      = fifo_rdata.data;
    assign o_tkeep      = fifo_rdata.keep;
    assign o_tlast      = fifo_rdata.last;
    assign o_byte_count = count_q;
    assign o_overflow   = overflow_q;
    assign o_done       = (state_q == StDone);

endmodule

// File: tb/tb_rc_byte_packer.sv
// Directed bench for rc_byte_packer: hand-computed word streams per scenario.
module tb_rc_byte_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [7:0]  byte_in;
    logic        finish;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic [31:0] byte_count;
    logic        overflow;
    logic        done;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } xfer_t;

    xfer_t got[$];

    always #5 clk = ~clk;

    rc_byte_packer #(
        .FIFO_DEPTH (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_we         (we),
        .i_byte       (byte_in),
        .i_finish     (finish),
        .o_tdata      (tdata),
        .o_tkeep      (tkeep),
        .o_tlast      (tlast),
        .o_tvalid     (tvalid),
        .i_tready     (tready),
        .o_byte_count (byte_count),
        .o_overflow   (overflow),
        .o_done       (done)
    );

    // Inputs change only at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (rst_n && tvalid && tready) got.push_back({tdata, tkeep, tlast});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        we      = 1'b0;
        finish  = 1'b0;
        byte_in = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            we      = 1'b1;
            byte_in = first + 8'(i);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic finish_and_wait(input string name);
        finish = 1'b1;
        tick();
        for (int i = 0; i < 40 && !done; i++) tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_timeout: got %b want 1", name, done);
        end
    endtask

    task automatic test_reset();
        tready = 1'b0;
        do_reset();
        vectors += 7;
        if (tvalid !== 1'b0)     begin miscompares++; $display("FAIL reset tvalid: got %b want 0", tvalid); end
        if (tdata !== 32'h0)     begin miscompares++; $display("FAIL reset tdata: got %h want 0", tdata); end
        if (tkeep !== 4'h0)      begin miscompares++; $display("FAIL reset tkeep: got %h want 0", tkeep); end
        if (tlast !== 1'b0)      begin miscompares++; $display("FAIL reset tlast: got %b want 0", tlast); end
        if (byte_count !== 32'd0) begin miscompares++; $display("FAIL reset count: got %0d want 0", byte_count); end
        if (overflow !== 1'b0)   begin miscompares++; $display("FAIL reset overflow: got %b want 0", overflow); end
        if (done !== 1'b0)       begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
    endtask

    task automatic test_two_words();
        xfer_t exp[2];
        exp[0] = {32'h04030201, 4'hF, 1'b0};
        exp[1] = {32'h08070605, 4'hF, 1'b1};
        do_reset();
        tready = 1'b1;
        send_bytes(8'h01, 8);
        finish_and_wait("two_words");
        tick();
        vectors++;
        if (got.size() != 2) begin
            miscompares++;
            $display("FAIL two_words nwords: got %0d want 2", got.size());
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL two_words word%0d: got %h want %h", i,
                         (i < got.size()) ? got[i] : xfer_t'('x), exp[i]);
            end
        end
        vectors++;
        if (byte_count !== 32'd8) begin
            miscompares++;
            $display("FAIL two_words count: got %0d want 8", byte_count);
        end
    endtask

    task automatic test_partial();
        xfer_t exp[2];
        exp[0] = {32'hDDCCBBAA, 4'hF, 1'b0};
        exp[1] = {32'h000000EE, 4'h1, 1'b1};
        do_reset();
        tready = 1'b1;
        send_bytes(8'hAA, 5);
        // AA+i gives AA,AB..; override with the real sequence
        do_reset();
        foreach (exp[i]) ;
        we = 1'b1; byte_in = 8'hAA; tick();
        byte_in = 8'hBB; tick();
        byte_in = 8'hCC; tick();
        byte_in = 8'hDD; tick();
        byte_in = 8'hEE; tick();
        we = 1'b0;
        finish_and_wait("partial");
        tick();
        vectors++;
        if (got.size() != 2) begin
            miscompares++;
            $display("FAIL partial nwords: got %0d want 2", got.size());
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL partial word%0d: got %h want %h", i,
                         (i < got.size()) ? got[i] : xfer_t'('x), exp[i]);
            end
        end
        vectors++;
        if (byte_count !== 32'd5) begin
            miscompares++;
            $display("FAIL partial count: got %0d want 5", byte_count);
        end
    endtask

    task automatic test_zero_bytes();
        do_reset();
        tready = 1'b1;
        finish = 1'b1;
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero done_early: got %b want 0", done);
        end
        tick();
        vectors += 3;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL zero done: got %b want 1", done);
        end
        if (got.size() != 0) begin
            miscompares++;
            $display("FAIL zero nwords: got %0d want 0", got.size());
        end
        if (byte_count !== 32'd0) begin
            miscompares++;
            $display("FAIL zero count: got %0d want 0", byte_count);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        do_reset();
        tready = 1'b0;
        send_bytes(8'h00, 12);
        vectors++;
        if (tvalid !== 1'b1 || tdata !== 32'h03020100) begin
            miscompares++;
            $display("FAIL ovf stall_head12: got v=%b %h want v=1 03020100", tvalid, tdata);
        end
        send_bytes(8'h0C, 28);
        vectors += 4;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf sticky: got %b want 1", overflow);
        end
        if (tdata !== 32'h03020100 || tkeep !== 4'hF || tlast !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf stall_head40: got %h/%h/%b want 03020100/f/0", tdata, tkeep, tlast);
        end
        if (byte_count !== 32'd40) begin
            miscompares++;
            $display("FAIL ovf count: got %0d want 40", byte_count);
        end
        if (got.size() != 0) begin
            miscompares++;
            $display("FAIL ovf early_xfer: got %0d want 0", got.size());
        end
        finish = 1'b1;
        tick();
        tick();
        tick();
        tready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        vectors++;
        if (got.size() != 8) begin
            miscompares++;
            $display("FAIL ovf nwords: got %0d want 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            vectors++;
            if (i >= got.size() || got[i] !== {w, 4'hF, 1'b0}) begin
                miscompares++;
                $display("FAIL ovf word%0d: got %h want %h", i,
                         (i < got.size()) ? got[i] : xfer_t'('x), {w, 4'hF, 1'b0});
            end
        end
    endtask

    task automatic test_same_cycle();
        xfer_t exp[2];
        exp[0] = {32'h13121110, 4'hF, 1'b0};
        exp[1] = {32'h00001514, 4'h3, 1'b1};
        do_reset();
        tready = 1'b1;
        send_bytes(8'h10, 5);
        we      = 1'b1;
        byte_in = 8'h15;
        finish  = 1'b1;
        tick();
        byte_in = 8'h99;
        tick();
        we = 1'b0;
        for (int i = 0; i < 40 && !done; i++) tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle done_timeout: got %b want 1", done);
        end
        tick();
        vectors++;
        if (got.size() != 2) begin
            miscompares++;
            $display("FAIL same_cycle nwords: got %0d want 2", got.size());
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL same_cycle word%0d: got %h want %h", i,
                         (i < got.size()) ? got[i] : xfer_t'('x), exp[i]);
            end
        end
        vectors++;
        if (byte_count !== 32'd6) begin
            miscompares++;
            $display("FAIL same_cycle count: got %0d want 6", byte_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tready = 1'b1;
        send_bytes(8'h01, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (byte_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid cleared: got %0d want 0", byte_count);
        end
        send_bytes(8'hA0, 4);
        finish_and_wait("reset_mid");
        tick();
        vectors += 3;
        if (got.size() != 1) begin
            miscompares++;
            $display("FAIL reset_mid nwords: got %0d want 1", got.size());
        end
        if (got.size() < 1 || got[0] !== {32'hA3A2A1A0, 4'hF, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid word0: got %h want %h",
                     (got.size() > 0) ? got[0] : xfer_t'('x), {32'hA3A2A1A0, 4'hF, 1'b1});
        end
        if (byte_count !== 32'd4) begin
            miscompares++;
            $display("FAIL reset_mid count: got %0d want 4", byte_count);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        byte_in = 8'h00;
        finish  = 1'b0;
        tready  = 1'b0;
        test_reset();
        test_two_words();
        test_partial();
        test_zero_bytes();
        test_overflow();
        test_same_cycle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
